// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver front end.
//
// Recovers 8N1 frames from the asynchronous rx_serial pin. Each good byte is
// presented as a one-cycle rx_dv strobe with uart_byte. Errored frames pulse
// frame_err or parity_err instead and never strobe rx_dv.
//
// Optional feature: define UART_RX_PARITY_EN to expect an even-parity bit
// between D7 and the stop bit (8E1 frames). When it is undefined, parity_err
// is a constant 0 and the PARITY state is absent.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit period (>= 8)
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   rx_serial   in   asynchronous UART line, idles high
//   rx_dv       out  one-cycle strobe: uart_byte holds a new good byte
//   uart_byte   out  last good byte (LSB received first), held until the next
//   frame_err   out  one-cycle pulse: stop bit sampled low
//   parity_err  out  one-cycle pulse: parity mismatch
//   busy        out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_serial,
   output logic       rx_dv,
   output logic [7:0] uart_byte,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy
);

   localparam int              CW      = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]   HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
   localparam logic [CW-1:0]   FULL_M1 = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_e;

   // Synchronizer and FSM state
   logic          r_sync1, r_rx_s;
   state_e        r_state,   w_state_nxt;
   logic [CW-1:0] r_clk_cnt, w_clk_cnt_nxt;
   logic [2:0]    r_bit_idx, w_bit_idx_nxt;
   logic [7:0]    r_shreg,   w_shreg_nxt;
   logic [7:0]    r_byte,    w_byte_nxt;
   logic          r_dv,      w_dv_nxt;
   logic          r_ferr,    w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
   logic          r_perr,    w_perr_nxt;
   logic          r_par_bad, w_par_bad_nxt;
`endif

   // Two-flop synchronizer. Both flops reset to the idle (high) level so a
   // reset release never looks like a start bit.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_rx_s  <= 1'b1;
      end else begin
         r_sync1 <= rx_serial;
         r_rx_s  <= r_sync1;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_clk_cnt <= '0;
         r_bit_idx <= '0;
         r_shreg   <= '0;
         r_byte    <= '0;
         r_dv      <= 1'b0;
         r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_perr    <= 1'b0;
         r_par_bad <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_clk_cnt <= w_clk_cnt_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_shreg   <= w_shreg_nxt;
         r_byte    <= w_byte_nxt;
         r_dv      <= w_dv_nxt;
         r_ferr    <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
         r_perr    <= w_perr_nxt;
         r_par_bad <= w_par_bad_nxt;
`endif
      end
   end

   // Next-state and next-datapath logic
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      w_state_nxt   = r_state;
      w_clk_cnt_nxt = r_clk_cnt;
      w_bit_idx_nxt = r_bit_idx;
      w_shreg_nxt   = r_shreg;
      w_byte_nxt    = r_byte;
      w_dv_nxt      = 1'b0;
      w_ferr_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_perr_nxt    = 1'b0;
      w_par_bad_nxt = r_par_bad;
`endif

      case (r_state)
         S_IDLE: begin
            w_clk_cnt_nxt = '0;
            w_bit_idx_nxt = '0;
            if (!r_rx_s) w_state_nxt = S_START;
         end

         // Re-check the line at mid start bit; a high level is a glitch.
         S_START: begin
            if (r_clk_cnt == HALF_M1) begin
               w_clk_cnt_nxt = '0;
               w_state_nxt   = r_rx_s ? S_IDLE : S_DATA;
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + 1'b1;
            end
         end

         S_DATA: begin
            if (r_clk_cnt == FULL_M1) begin
               w_clk_cnt_nxt          = '0;
               w_shreg_nxt[r_bit_idx] = r_rx_s;
               if (r_bit_idx == 3'd7) begin
                  w_bit_idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
                  w_state_nxt   = S_PARITY;
`else
                  w_state_nxt   = S_STOP;
`endif
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 1'b1;
               end
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + 1'b1;
            end
         end

`ifdef UART_RX_PARITY_EN
         // Even parity: data bits plus parity bit must hold an even count of 1s.
         S_PARITY: begin
            if (r_clk_cnt == FULL_M1) begin
               w_clk_cnt_nxt = '0;
               w_par_bad_nxt = ^{r_shreg, r_rx_s};
               w_state_nxt   = S_STOP;
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + 1'b1;
            end
         end
`endif

         // Leaving at mid stop bit lets the next start edge be caught with
         // no idle gap between frames.
         S_STOP: begin
            if (r_clk_cnt == FULL_M1) begin
               w_clk_cnt_nxt = '0;
               if (!r_rx_s) begin
                  w_ferr_nxt  = 1'b1;
                  w_state_nxt = S_BREAK;
`ifdef UART_RX_PARITY_EN
               end else if (r_par_bad) begin
                  w_perr_nxt  = 1'b1;
                  w_state_nxt = S_IDLE;
`endif
               end else begin
                  w_byte_nxt  = r_shreg;
                  w_dv_nxt    = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_clk_cnt_nxt = r_clk_cnt + 1'b1;
            end
         end

         // Hold off until a held-low break releases, so it cannot re-trigger.
         S_BREAK: begin
            if (r_rx_s) w_state_nxt = S_IDLE;
         end

         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign rx_dv      = r_dv;
   assign uart_byte  = r_byte;
   assign frame_err  = r_ferr;
`ifdef UART_RX_PARITY_EN
   assign parity_err = r_perr;
`else
   assign parity_err = 1'b0;
`endif
   assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- scoreboard bench for uart_rx with CLKS_PER_BIT = 16.
//
// The driver serialises frames bit by bit. A frame-level reference model
// derives the expected pulse (kind, byte on uart_byte, cycle of arrival) from
// the frame contents and pushes it into a queue; an independent monitor pops
// and compares whenever the DUT pulses rx_dv, frame_err or parity_err.
// Honours UART_RX_PARITY_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS = 11;
   localparam bit PAR   = 1'b1;
`else
   localparam int NBITS = 10;
   localparam bit PAR   = 1'b0;
`endif
   // Pin falling edge to pulse: 2 sync + 1 IDLE->START + half bit + rest of frame
   localparam int LAT = 3 + CPB/2 + (NBITS - 1) * CPB;

   localparam int EV_DV   = 0;
   localparam int EV_FERR = 1;
   localparam int EV_PERR = 2;

   typedef struct {
      int         kind;
      logic [7:0] data;
      int         cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_serial;
   logic       rx_dv;
   logic [7:0] uart_byte;
   logic       frame_err;
   logic       parity_err;
   logic       busy;

   ev_t        exp_q[$];
   ev_t        mon_e;
   int         checks = 0;
   int         errors = 0;
   int         cyc    = 0;
   logic [7:0] model_byte = 8'h00;
   logic [47:0] pkt = '0;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_serial  (rx_serial),
      .rx_dv      (rx_dv),
      .uart_byte  (uart_byte),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: expected response of a whole frame, then drive it.
   // All driver tasks start and end 1 time unit after a rising edge.
   task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop_val);
      logic [10:0] bits;
      ev_t         e;
      bits = '1;
      bits[0] = 1'b0;
      bits[8:1] = d;
      if (PAR) begin
         bits[9]  = (^d) ^ par_flip;
         bits[10] = stop_val;
      end else begin
         bits[9] = stop_val;
      end
      e.cyc = cyc + LAT;
      if (!stop_val) begin
         e.kind = EV_FERR; e.data = model_byte;
      end else if (PAR && par_flip) begin
         e.kind = EV_PERR; e.data = model_byte;
      end else begin
         e.kind = EV_DV; e.data = d; model_byte = d;
      end
      exp_q.push_back(e);
      for (int i = 0; i < NBITS; i++) begin
         rx_serial = bits[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      rx_serial = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: compare every pulse against the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
            mon_e = exp_q.pop_front();
            errors++; checks++;
            $display("FAIL missing_pulse: actual=none expected kind %0d at cycle %0d", mon_e.kind, mon_e.cyc);
         end
         if (rx_dv || frame_err || parity_err) begin
            check("one_pulse", 64'(rx_dv) + 64'(frame_err) + 64'(parity_err), 1);
            if (exp_q.size() == 0) begin
               errors++; checks++;
               $display("FAIL unexpected_pulse: actual dv=%0b ferr=%0b perr=%0b expected none (cycle %0d)",
                        rx_dv, frame_err, parity_err, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               check("pulse_kind", rx_dv ? EV_DV : (frame_err ? EV_FERR : EV_PERR), mon_e.kind);
               check("uart_byte", uart_byte, mon_e.data);
               check("pulse_cycle", cyc, mon_e.cyc);
               if (rx_dv) pkt = {pkt[39:0], uart_byte};
            end
         end
      end
   end

   initial begin
      int n;
      rst_n     = 1'b0;
      rx_serial = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rx_dv", rx_dv, 0);
      check("reset_uart_byte", uart_byte, 8'h00);
      check("reset_frame_err", frame_err, 0);
      check("reset_parity_err", parity_err, 0);
      check("reset_busy", busy, 0);
      rst_n = 1'b1;
      idle(5);

      // Single byte
      send_frame(8'hA5, 0, 1);
      idle(20);

      // Back-to-back stream with no idle gap
      for (int i = 1; i <= 6; i++) send_frame(8'(i), 0, 1);
      idle(20);
      check("packet_48b", pkt, 48'h010203040506);

      // False start: 5-cycle low glitch
      rx_serial = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      idle(30);
      check("false_start_idle", busy, 0);
      send_frame(8'h3C, 0, 1);
      idle(20);

      // Break: stop bit low, line held low for 40 bit times
      send_frame(8'h99, 0, 0);
      rx_serial = 1'b0;
      for (int i = 0; i < 40; i++) begin
         repeat (CPB) @(posedge clk);
         #1;
         if (i % 8 == 0) check("break_busy", busy, 1);
      end
      idle(4);
      check("break_release_idle", busy, 0);
      idle(20);
      send_frame(8'h7E, 0, 1);
      idle(20);

      // Reset during D3 of 0xFF
      rx_serial = 1'b0;
      repeat (CPB) @(posedge clk);
      #1;
      rx_serial = 1'b1;
      repeat (3 * CPB + CPB / 2) @(posedge clk);
      #1;
      check("pre_reset_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("midreset_busy", busy, 0);
      check("midreset_rx_dv", rx_dv, 0);
      check("midreset_uart_byte", uart_byte, 8'h00);
      model_byte = 8'h00;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(20);
      send_frame(8'h55, 0, 1);
      idle(20);

      if (PAR) begin
         send_frame(8'h03, 0, 1);
         idle(10);
         send_frame(8'h03, 1, 1);
         idle(10);
      end

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         int r;
         bit ferr, pflip;
         r     = $urandom_range(0, 9);
         ferr  = (r == 8);
         pflip = PAR && (r == 9);
         send_frame(8'($urandom), pflip, !ferr);
         n = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
         if (ferr) n = n + 20;
         if (n > 0) idle(n);
      end
      idle(5);

      // Drain with a bounded wait
      n = 0;
      while (exp_q.size() > 0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      check("final_uart_byte", uart_byte, model_byte);
      check("final_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver front end of the host link. Oversamples the asynchronous `rx_serial` pin, recovers 8N1 frames (or 8E1 frames when parity is compiled in), and presents each good byte as a one-cycle `rx_dv` strobe with `uart_byte`. It sits directly upstream of the 48-bit UART packetizer, which consumes `rx_dv`/`uart_byte` unchanged. Errored frames are reported on separate pulses and never strobe `rx_dv`.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per bit period (100 MHz / 115200); legal values are ≥ 8.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `rx_serial`  input  1  asynchronous UART line; idles high.
- `rx_dv`  output  1  one-cycle strobe: `uart_byte` holds a new good byte.
- `uart_byte`  output  8  last good byte, LSB received first; held until the next good byte.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  output  1  one-cycle pulse: parity mismatch. Tied to 0 when parity is compiled out.
- `busy`  output  1  high whenever the state is not IDLE.

## Operation
- **Synchronizer.** `rx_serial` passes through a 2-flop synchronizer; both flops reset to 1. All logic sees only the synchronized line `rx_s`.
- **Counters.**
  - Bit-period counter `clk_cnt` has width `$clog2(CLKS_PER_BIT)`.
  - Bit index `bit_idx` runs 0–7.
  - Shift register `shreg` is 8 bits wide.
- **States:**
  - **IDLE**
    - Clears `clk_cnt` and `bit_idx`.
    - `rx_s == 0` → START.
  - **START**
    - Counts to `CLKS_PER_BIT/2 - 1`, then samples `rx_s`.
    - If `rx_s` is 0 → DATA with `clk_cnt = 0`.
    - If `rx_s` is 1 → false start; return to IDLE with no pulse.
  - **DATA**
    - Counts to `CLKS_PER_BIT - 1`, then samples `rx_s` into `shreg[bit_idx]` and clears `clk_cnt`.
    - After `bit_idx == 7` → PARITY (if compiled in), else STOP.
  - **PARITY** (compiled in only)
    - Waits one bit period, then samples the parity bit.
    - Records a mismatch flag → STOP.
  - **STOP**
    - Waits one bit period, then samples the stop bit.
    - Stop = 1 and no parity mismatch: `uart_byte <= shreg`, `rx_dv = 1`, → IDLE.
    - Stop = 1 and parity mismatch: `parity_err = 1`, `uart_byte` unchanged, → IDLE.
    - Stop = 0: `frame_err = 1` only (framing error takes priority over parity), → BREAK_WAIT.
  - **BREAK_WAIT**
    - Stays here while `rx_s == 0`.
    - `rx_s == 1` → IDLE. This prevents a held-low break from re-triggering a frame every 10 bits.
- **Output pulses.** `rx_dv`, `frame_err` and `parity_err` are registered and high for exactly one cycle. At most one of them pulses per frame.
- **Reset.**
  - `rst_n` low, including mid-frame, forces IDLE.
  - All outputs go to 0, `uart_byte` to 8'h00, and the synchronizer flops to 1.
  - The partial frame is discarded. The first frame is recognized only after a falling edge seen following release.

## Timing
- Reset values: `rx_dv = 0`, `uart_byte = 8'h00`, `frame_err = 0`, `parity_err = 0`, `busy = 0`.
- Sample points fall at mid-bit: `CLKS_PER_BIT/2 + k*CLKS_PER_BIT` cycles after START entry, k = 1..9 (k = 10 for the stop bit with parity).
- Latency, pin falling edge to `rx_dv` rising:
  - 8N1: 2 (sync) + 1 (IDLE→START) + `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` cycles.
  - 8E1: one further `CLKS_PER_BIT`.
- Back-to-back frames: the FSM returns to IDLE half a bit before the stop bit ends. The next start bit is detected with no gap, so continuous 115200-baud traffic loses nothing.
- Tolerates ±4% baud mismatch.
- No backpressure: the downstream stage must accept `rx_dv` every cycle it is asserted.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - Adds the PARITY state and expects an even-parity bit between D7 and the stop bit.
  - A mismatch suppresses `rx_dv` and pulses `parity_err`.
- **Not defined:**
  - Frames are 8N1.
  - `parity_err` is a constant 0.
  - The PARITY state and its logic are absent.

## Test plan
Bench uses `CLKS_PER_BIT = 16`, so the 8N1 latency is 3 + 8 + 144 = 155 cycles.

- **Single byte.** Send 0xA5 8N1 → exactly one `rx_dv` pulse 155 cycles after the falling edge; `uart_byte = 8'hA5`; `frame_err = 0`.
- **Back-to-back stream.** Send 0x01 02 03 04 05 06 with no idle gap → six `rx_dv` pulses in order, each 160 cycles apart. A downstream packetizer sees frame 48'h010203040506.
- **False start.** Low glitch of 5 cycles on `rx_serial` → return to IDLE; no `rx_dv` or `frame_err`. A following 0x3C is received correctly.
- **Break.** Stop bit forced low, then line held low for 40 bit times → one `frame_err` pulse; no `rx_dv`; `busy` stays high until the line rises. Then 0x7E is received normally.
- **Reset mid-frame.** Assert `rst_n` low during D3 of 0xFF → `busy`, `rx_dv` and `uart_byte` go to 0 immediately. After release, 0x55 is received with `uart_byte = 8'h55`.
- **Parity (`UART_RX_PARITY_EN`).**
  - 0x03 with parity bit 0 → `rx_dv` pulse, `uart_byte = 8'h03`.
  - 0x03 with parity bit 1 → one `parity_err` pulse; no `rx_dv`; `uart_byte` unchanged.
